dma_channel_arbiter: RTL and testbench

Parametrised channel arbiter and transfer-cycle sequencer for the DMA controller. It samples the per-channel DREQ lines, selects one channel under fixed or rotating priority, runs the HRQ/HLDA bus handshake, and steps the selected channel through the SI/S0/S1/S2/S4 transfer states. It drives DACK, AEN and ADSTB. It generalises the 4-channel, fixed-priority-only behaviour to NUM_CH channels and adds rotating priority, per-channel masking, block mode, and abort on HLDA loss.

---
 rtl/dma_channel_arbiter_if.sv | 32 +++
 rtl/dma_channel_arbiter.sv | 123 ++++++++++++
 tb/tb_dma_channel_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/dma_channel_arbiter_if.sv
// Bus bundle between a DMA channel arbiter and its requesters/CPU side.
// master drives requests and hold acknowledge; slave is the arbiter.
interface dma_channel_arbiter_if #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH)
);
   logic [NUM_CH-1:0] DREQ;
   logic [NUM_CH-1:0] maskReg;
   logic [NUM_CH-1:0] blockMode;
   logic              rotatePriority;
   logic              HLDA;
   logic              EOP_N;
   logic              tc;
   logic              HRQ;
   logic [NUM_CH-1:0] DACK;
   logic              AEN;
   logic              ADSTB;
   logic [CH_W-1:0]   grantId;
   logic [4:0]        state;

   modport master (
      output DREQ, maskReg, blockMode, rotatePriority,
      output HLDA, EOP_N, tc,
      input  HRQ, DACK, AEN, ADSTB, grantId, state
   );

   modport slave (
      input  DREQ, maskReg, blockMode, rotatePriority,
      input  HLDA, EOP_N, tc,
      output HRQ, DACK, AEN, ADSTB, grantId, state
   );
endinterface

// File: rtl/dma_channel_arbiter.sv
// DMA channel arbiter: fixed/rotating priority grant, HRQ/HLDA handshake
// and SI/S0/S1/S2/S4 transfer sequencing with block mode and EOP abort.
module dma_channel_arbiter #(
   parameter int NUM_CH = 4,
   parameter int CH_W   = $clog2(NUM_CH)
) (
   input logic             CLK,
   input logic             RESET,
   dma_channel_arbiter_if.slave bus
);
   typedef enum logic [4:0] {
      SI = 5'b00001,
      S0 = 5'b00010,
      S1 = 5'b00100,
      S2 = 5'b01000,
      S4 = 5'b10000
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [CH_W-1:0]   r_grant;
   logic [CH_W-1:0]   r_last_ch;
   logic [CH_W-1:0]   w_winner;
   logic [NUM_CH-1:0] w_elig;
   logic              w_any;
   logic              w_complete;
   logic              w_xfer;
   logic              w_more;
   int                w_idx;

   assign w_elig = bus.DREQ & ~bus.maskReg;
   assign w_any  = |w_elig;

   // Scan downward so the last hit is the highest-priority candidate.
   always_comb begin
      w_winner = '0;
      w_idx    = 0;
      if (bus.rotatePriority) begin
         for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = (int'(r_last_ch) + k) % NUM_CH;
            if (w_elig[w_idx[CH_W-1:0]])
               w_winner = w_idx[CH_W-1:0];
         end
      end else begin
         for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_elig[i])
               w_winner = CH_W'(i);
         end
      end
   end

   assign w_more = bus.blockMode[r_grant] & ~bus.tc
                 & bus.DREQ[r_grant] & bus.EOP_N;

   always_comb begin
      w_next     = r_state;
      w_complete = 1'b0;
      unique case (r_state)
         SI: begin
            if (w_any)
               w_next = S0;
         end
         S0: begin
            if (!bus.EOP_N) begin
               w_next     = SI;
               w_complete = 1'b1;
            end else if (bus.HLDA) begin
               w_next = S1;
            end else if (!w_elig[r_grant]) begin
               w_next = SI;
            end
         end
         S1, S2: begin
            if (!bus.EOP_N) begin
               w_next     = SI;
               w_complete = 1'b1;
            end else if (!bus.HLDA) begin
               w_next = SI;
            end else begin
               w_next = (r_state == S1) ? S2 : S4;
            end
         end
         S4: begin
            if (!bus.EOP_N) begin
               w_next     = SI;
               w_complete = 1'b1;
            end else if (!bus.HLDA) begin
               w_next = SI;
            end else if (w_more) begin
               w_next = S1;
            end else begin
               w_next     = SI;
               w_complete = 1'b1;
            end
         end
         default: w_next = SI;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state   <= SI;
         r_grant   <= '0;
         r_last_ch <= CH_W'(NUM_CH - 1);
      end else begin
         r_state <= w_next;
         if (r_state == SI && w_any)
            r_grant <= w_winner;
         if (w_complete && bus.rotatePriority)
            r_last_ch <= r_grant;
      end
   end

   assign w_xfer = (r_state == S1) | (r_state == S2)
                 | (r_state == S4);

   assign bus.HRQ     = (r_state != SI);
   assign bus.AEN     = w_xfer;
   assign bus.ADSTB   = (r_state == S1);
   assign bus.DACK    = w_xfer ? (NUM_CH'(1) << r_grant) : '0;
   assign bus.grantId = r_grant;
   assign bus.state   = r_state;
endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Directed bench for dma_channel_arbiter with a grant scoreboard
// popped on every ADSTB pulse.
module tb_dma_channel_arbiter;
   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;
   localparam logic [4:0] ST_SI = 5'b00001;
   localparam logic [4:0] ST_S0 = 5'b00010;
   localparam logic [4:0] ST_S1 = 5'b00100;
   localparam logic [4:0] ST_S2 = 5'b01000;
   localparam logic [4:0] ST_S4 = 5'b10000;

   logic CLK = 1'b0;
   logic RESET;
   int   n_asrt = 0;
   int   n_fail = 0;
   logic [NUM_CH-1:0] exp_q[$];
   logic [NUM_CH-1:0] mon_exp;

   dma_channel_arbiter_if #(.NUM_CH(NUM_CH), .CH_W(CH_W)) bus();

   dma_channel_arbiter #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus.slave)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_state(input string tag, input logic [4:0] tgt,
                             input int budget);
      for (int i = 0; i < budget; i++) begin
         if (bus.state === tgt) break;
         step();
      end
      chk(tag, 32'(bus.state), 32'(tgt));
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
   endtask

   // Scoreboard: each transfer start must match the oldest queued grant.
   always @(negedge CLK) begin
      if (RESET === 1'b0 && bus.ADSTB === 1'b1) begin
         chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            chk("sb_dack", 32'(bus.DACK), 32'(mon_exp));
            chk("sb_aen", 32'(bus.AEN), 32'd1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      RESET              = 1'b1;
      bus.DREQ           = '0;
      bus.maskReg        = '0;
      bus.blockMode      = '0;
      bus.rotatePriority = 1'b0;
      bus.HLDA           = 1'b0;
      bus.EOP_N          = 1'b1;
      bus.tc             = 1'b0;
      #2;
      chk("rst_state", 32'(bus.state), 32'(ST_SI));
      chk("rst_hrq", 32'(bus.HRQ), 32'd0);
      chk("rst_dack", 32'(bus.DACK), 32'd0);
      chk("rst_aen", 32'(bus.AEN), 32'd0);
      chk("rst_adstb", 32'(bus.ADSTB), 32'd0);
      chk("rst_grant", 32'(bus.grantId), 32'd0);
      chk("rst_lastch", 32'(dut.r_last_ch), 32'd3);
      step();
      RESET = 1'b0;

      // Fixed priority, lowest eligible index wins.
      bus.HLDA = 1'b1;
      bus.DREQ = 4'b0110;
      exp_q.push_back(4'b0010);
      step();
      chk("fx_s0", 32'(bus.state), 32'(ST_S0));
      chk("fx_s0_hrq", 32'(bus.HRQ), 32'd1);
      chk("fx_s0_dack", 32'(bus.DACK), 32'd0);
      step();
      chk("fx_s1", 32'(bus.state), 32'(ST_S1));
      chk("fx_s1_adstb", 32'(bus.ADSTB), 32'd1);
      bus.DREQ = '0;
      step();
      chk("fx_s2", 32'(bus.state), 32'(ST_S2));
      chk("fx_s2_adstb", 32'(bus.ADSTB), 32'd0);
      chk("fx_s2_dack", 32'(bus.DACK), 32'b0010);
      step();
      chk("fx_s4", 32'(bus.state), 32'(ST_S4));
      chk("fx_s4_dack", 32'(bus.DACK), 32'b0010);
      chk("fx_s4_hrq", 32'(bus.HRQ), 32'd1);
      step();
      chk("fx_si", 32'(bus.state), 32'(ST_SI));
      chk("fx_si_hrq", 32'(bus.HRQ), 32'd0);
      chk("fx_si_dack", 32'(bus.DACK), 32'd0);

      // Rotating priority with all channels requesting.
      do_reset();
      bus.rotatePriority = 1'b1;
      bus.DREQ = 4'b1111;
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0010);
      exp_q.push_back(4'b0100);
      exp_q.push_back(4'b1000);
      exp_q.push_back(4'b0001);
      repeat (25) step();
      bus.DREQ = '0;
      chk("rot_si", 32'(bus.state), 32'(ST_SI));
      chk("rot_lastch", 32'(dut.r_last_ch), 32'd0);
      chk("rot_q_empty", 32'(exp_q.size()), 32'd0);

      // Masked channel 0, CPU withholds HLDA.
      do_reset();
      bus.rotatePriority = 1'b0;
      bus.maskReg = 4'b0001;
      bus.HLDA = 1'b0;
      bus.DREQ = 4'b0011;
      exp_q.push_back(4'b0010);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("hold_state", 32'(bus.state), 32'(ST_S0));
         chk("hold_hrq", 32'(bus.HRQ), 32'd1);
         chk("hold_dack", 32'(bus.DACK), 32'd0);
         step();
      end
      chk("hold_grant", 32'(bus.grantId), 32'd1);
      bus.HLDA = 1'b1;
      step();
      chk("hold_s1", 32'(bus.state), 32'(ST_S1));
      bus.DREQ = '0;
      wait_state("hold_done", ST_SI, 10);
      bus.maskReg = '0;

      // Block mode on channel 2, tc on the third S4.
      bus.blockMode = 4'b0100;
      bus.DREQ = 4'b0100;
      repeat (3) exp_q.push_back(4'b0100);
      step();
      chk("blk_s0", 32'(bus.state), 32'(ST_S0));
      for (int g = 0; g < 3; g++) begin
         step();
         chk("blk_s1", 32'(bus.state), 32'(ST_S1));
         step();
         chk("blk_s2", 32'(bus.state), 32'(ST_S2));
         step();
         chk("blk_s4", 32'(bus.state), 32'(ST_S4));
         if (g == 2) bus.tc = 1'b1;
      end
      step();
      chk("blk_si", 32'(bus.state), 32'(ST_SI));
      bus.DREQ = '0;
      bus.tc = 1'b0;
      bus.blockMode = '0;

      // EOP in S2 counts as completion under rotation.
      do_reset();
      bus.rotatePriority = 1'b1;
      bus.DREQ = 4'b0100;
      exp_q.push_back(4'b0100);
      step();
      step();
      step();
      chk("eop_s2", 32'(bus.state), 32'(ST_S2));
      bus.EOP_N = 1'b0;
      bus.DREQ = '0;
      step();
      chk("eop_si", 32'(bus.state), 32'(ST_SI));
      chk("eop_dack", 32'(bus.DACK), 32'd0);
      chk("eop_lastch", 32'(dut.r_last_ch), 32'd2);
      bus.EOP_N = 1'b1;

      // HLDA loss in S1 aborts without rotation.
      bus.DREQ = 4'b0010;
      exp_q.push_back(4'b0010);
      step();
      step();
      chk("abt_s1", 32'(bus.state), 32'(ST_S1));
      bus.HLDA = 1'b0;
      bus.DREQ = '0;
      step();
      chk("abt_si", 32'(bus.state), 32'(ST_SI));
      chk("abt_hrq", 32'(bus.HRQ), 32'd0);
      chk("abt_lastch", 32'(dut.r_last_ch), 32'd2);
      bus.HLDA = 1'b1;

      // Asynchronous reset mid-transfer.
      bus.DREQ = 4'b0001;
      exp_q.push_back(4'b0001);
      step();
      step();
      step();
      chk("mrst_s2", 32'(bus.state), 32'(ST_S2));
      chk("mrst_aen", 32'(bus.AEN), 32'd1);
      RESET = 1'b1;
      #1;
      chk("mrst_state", 32'(bus.state), 32'(ST_SI));
      chk("mrst_hrq", 32'(bus.HRQ), 32'd0);
      chk("mrst_dack", 32'(bus.DACK), 32'd0);
      chk("mrst_aen0", 32'(bus.AEN), 32'd0);
      chk("mrst_adstb", 32'(bus.ADSTB), 32'd0);
      chk("mrst_lastch", 32'(dut.r_last_ch), 32'd3);
      bus.DREQ = '0;
      step();
      RESET = 1'b0;
      step();
      chk("end_state", 32'(bus.state), 32'(ST_SI));
      chk("end_q_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_asrt, n_fail);
      $finish;
   end
endmodule
